// File: rtl/mips_instr_sequencer_pkg.sv
// Shared types and constants for the MiniMIPS instruction sequencer:
// sequencer state encoding, HALT sentinel opcode and instruction field positions.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;

  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OPC_HALT);
  endfunction

endpackage

// File: rtl/mips_instr_sequencer_if.sv
// Instruction/result handshake between the sequencer (master) and the MiniMIPS core (slave).
interface mips_instr_sequencer_if #(
  parameter int IW = 16,
  parameter int RW = 32
) ();

  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [RW-1:0] result_in;
  logic          result_valid;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  result_in,
    input  result_valid
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output result_in,
    output result_valid
  );

endinterface

// File: rtl/mips_instr_sequencer_instr_store.sv
// Program store: DEPTH x IW words, one synchronous write port and one synchronous read port.
// Only the read data register is reset; the array contents survive reset.
module instr_store #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data only moves on a read strobe so the issued word stays stable afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= {IW{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_instr_sequencer.sv
// Instruction-issuing end of the MiniMIPS interface: walks a PC over the program store,
// issues one word at a time with valid/ready and waits for each core result.
module mips_instr_sequencer
  import mips_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int IW    = 16,
  parameter int RW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic [AW-1:0]          load_addr,
  input  logic [IW-1:0]          load_data,
  input  logic                   start,
  input  logic                   halt_req,
  mips_instr_sequencer_if.master core_if,
  output logic [AW-1:0]          pc_out,
  output logic                   busy,
  output logic                   done,
  output logic [RW-1:0]          last_result,
  output logic [AW:0]            result_count
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [RW-1:0] last_result_q, last_result_d;
  logic [AW:0]   count_q, count_d;

  logic [IW-1:0] rd_data_s;
  logic          busy_s;
  logic          halt_word_s;

  assign busy_s      = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_WAIT_RES);
  assign halt_word_s = is_halt(rd_data_s);

  instr_store #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (load_en && !busy_s),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (state_q == ST_FETCH),
    .raddr_i (pc_q),
    .rdata_o (rd_data_s)
  );

  // Next-state logic; halt_req while running overrides any handshake or result.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    last_result_d = last_result_q;
    count_d       = count_q;
    if (halt_req && busy_s) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = {AW{1'b0}};
            count_d = {(AW+1){1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        ST_FETCH: begin
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (halt_word_s) begin
            state_d = ST_DONE;
          end else if (core_if.instr_ready) begin
            state_d = ST_WAIT_RES;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT_RES: begin
          if (core_if.result_valid) begin
            last_result_d = core_if.result_in;
            count_d       = count_q + {{AW{1'b0}}, 1'b1};
            // The PC parks on the last word instead of wrapping.
            if (pc_q == AW'(DEPTH - 1)) begin
              state_d = ST_DONE;
            end else begin
              pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
              state_d = ST_FETCH;
            end
          end else begin
            state_d = ST_WAIT_RES;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= {AW{1'b0}};
      last_result_q <= {RW{1'b0}};
      count_q       <= {(AW+1){1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      last_result_q <= last_result_d;
      count_q       <= count_d;
    end
  end

  assign core_if.instr_out   = rd_data_s;
  assign core_if.instr_valid = (state_q == ST_ISSUE) && !halt_word_s;
  assign pc_out              = pc_q;
  assign busy                = busy_s;
  assign done                = (state_q == ST_DONE);
  assign last_result         = last_result_q;
  assign result_count        = count_q;

endmodule

// File: tb/tb_mips_instr_sequencer.sv
// Directed self-checking bench for mips_instr_sequencer with a hand-driven core model.
module tb_mips_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        halt_req;
  logic [5:0]  pc_out;
  logic        busy;
  logic        done;
  logic [31:0] last_result;
  logic [6:0]  result_count;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int hs_base;

  mips_instr_sequencer_if #(.IW(16), .RW(32)) core_if ();

  mips_instr_sequencer #(
    .DEPTH (64),
    .AW    (6),
    .IW    (16),
    .RW    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .halt_req     (halt_req),
    .core_if      (core_if),
    .pc_out       (pc_out),
    .busy         (busy),
    .done         (done),
    .last_result  (last_result),
    .result_count (result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_if.instr_valid && core_if.instr_ready) begin
      hs_count <= hs_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [5:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for an issue, optionally stalls ready, then returns one result.
  task automatic issue_one(input logic [15:0] exp_i, input logic [31:0] res, input int stall);
    int k;
    k = 0;
    while (!core_if.instr_valid && k < 10) begin
      step();
      k++;
    end
    chk("issue_valid", {31'd0, core_if.instr_valid}, 32'd1);
    chk("issue_instr", {16'd0, core_if.instr_out}, {16'd0, exp_i});
    core_if.instr_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", {31'd0, core_if.instr_valid}, 32'd1);
      chk("stall_instr", {16'd0, core_if.instr_out}, {16'd0, exp_i});
    end
    core_if.instr_ready = 1'b1;
    step();
    core_if.instr_ready = 1'b0;
    chk("wait_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    core_if.result_in    = res;
    core_if.result_valid = 1'b1;
    step();
    core_if.result_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_en = 1'b0;
    load_addr = 6'd0;
    load_data = 16'd0;
    start = 1'b0;
    halt_req = 1'b0;
    core_if.instr_ready = 1'b0;
    core_if.result_in = 32'd0;
    core_if.result_valid = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, core_if.instr_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pc", {26'd0, pc_out}, 32'd0);
    chk("rst_count", {25'd0, result_count}, 32'd0);
    chk("rst_last", last_result, 32'd0);
    rst_n = 1'b1;
    step();

    // Three-word program ending in HALT.
    load_word(6'd0, 16'h0761);
    load_word(6'd1, 16'h2767);
    load_word(6'd2, 16'hF000);
    hs_base = hs_count;
    do_start();
    chk("lat_fetch_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("lat_fetch_busy", {31'd0, busy}, 32'd1);
    step();
    chk("lat_issue_valid", {31'd0, core_if.instr_valid}, 32'd1);
    issue_one(16'h0761, 32'h5, 0);
    chk("mid_count", {25'd0, result_count}, 32'd1);
    chk("mid_last", last_result, 32'h5);
    issue_one(16'h2767, 32'h7, 0);
    step();
    chk("halt_word_valid", {31'd0, core_if.instr_valid}, 32'd0);
    step();
    chk("p1_done", {31'd0, done}, 32'd1);
    chk("p1_busy", {31'd0, busy}, 32'd0);
    chk("p1_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("p1_count", {25'd0, result_count}, 32'd2);
    chk("p1_last", last_result, 32'h7);
    chk("p1_pc", {26'd0, pc_out}, 32'd2);
    chk("p1_issues", hs_count - hs_base, 32'd2);

    // Rerun with a 5-cycle ready stall while load_en hammers address 0.
    hs_base = hs_count;
    do_start();
    chk("rerun_count_clr", {25'd0, result_count}, 32'd0);
    chk("rerun_last_kept", last_result, 32'h7);
    load_en = 1'b1;
    load_addr = 6'd0;
    load_data = 16'h1111;
    issue_one(16'h0761, 32'h9, 5);
    issue_one(16'h2767, 32'hA, 0);
    step();
    step();
    load_en = 1'b0;
    chk("p2_done", {31'd0, done}, 32'd1);
    chk("p2_count", {25'd0, result_count}, 32'd2);
    chk("p2_last", last_result, 32'hA);
    chk("p2_issues", hs_count - hs_base, 32'd2);

    // Store must be unchanged; halt in WAIT_RES drops the simultaneous result.
    do_start();
    issue_one(16'h0761, 32'h0, 0);
    // issue_one already returned a result; run the second up to WAIT_RES by hand.
    step();
    chk("h_issue_instr", {16'd0, core_if.instr_out}, 32'h2767);
    core_if.instr_ready = 1'b1;
    step();
    core_if.instr_ready = 1'b0;
    core_if.result_in = 32'hDEADBEEF;
    core_if.result_valid = 1'b1;
    halt_req = 1'b1;
    step();
    core_if.result_valid = 1'b0;
    halt_req = 1'b0;
    chk("h_done", {31'd0, done}, 32'd1);
    chk("h_busy", {31'd0, busy}, 32'd0);
    chk("h_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("h_count", {25'd0, result_count}, 32'd1);
    chk("h_last", last_result, 32'h0);
    chk("h_pc", {26'd0, pc_out}, 32'd1);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("h_idle_halt_done", {31'd0, done}, 32'd1);

    // Reset during ISSUE.
    do_start();
    step();
    chk("r_issue_valid", {31'd0, core_if.instr_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("r_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_done", {31'd0, done}, 32'd0);
    chk("r_count", {25'd0, result_count}, 32'd0);
    chk("r_last", last_result, 32'd0);
    step();
    chk("r_idle_busy", {31'd0, busy}, 32'd0);

    // Full 64-word program, no HALT: must stop at pc 63 without wrapping.
    for (int i = 0; i < 64; i++) begin
      load_word(6'(i), 16'h1000 | 16'(i));
    end
    hs_base = hs_count;
    do_start();
    for (int i = 0; i < 64; i++) begin
      issue_one(16'h1000 | 16'(i), 32'd100 + 32'(i), 0);
    end
    chk("f_done", {31'd0, done}, 32'd1);
    chk("f_pc", {26'd0, pc_out}, 32'd63);
    chk("f_count", {25'd0, result_count}, 32'd64);
    chk("f_last", last_result, 32'd163);
    chk("f_issues", hs_count - hs_base, 32'd64);
    step();
    step();
    chk("f_nowrap_pc", {26'd0, pc_out}, 32'd63);
    chk("f_nowrap_valid", {31'd0, core_if.instr_valid}, 32'd0);
    chk("f_nowrap_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
